// File: rtl/pri_encoder_rr.sv
// pri_encoder_rr: registered priority encoder for active-low request lines.
// A winning request index is captured and held as a grant until the consumer
// acknowledges it. Two priority modes are available:
//   RR_MODE = 0 : fixed priority, the highest active index wins.
//   RR_MODE = 1 : round-robin priority. The search starts at pointer P and
//                 moves downward, wrapping from 0 to N-1. After a grant is
//                 acknowledged, P moves to the index just below that grant.
// oEO is a registered "enabled but nothing requested" flag, used when
// several encoders are cascaded.
`timescale 1ns/1ps

module pri_encoder_rr #(
    parameter int N       = 8,           // number of request lines, 2..32
    parameter int W       = $clog2(N),   // index width; derived, leave at default
    parameter int RR_MODE = 0            // 0 = fixed priority, 1 = round-robin
) (
    input  logic         iClk,
    input  logic         iRst,    // synchronous, active-high
    input  logic         iEI,     // active-low enable
    input  logic [N-1:0] iData,   // active-low request lines
    input  logic         iAck,    // grant acknowledge
    output logic [W-1:0] oData,   // index of the granted request
    output logic         oValid,  // oData holds a live grant
    output logic         oEO      // active-low: enabled with no request
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   data_q,  data_d;
    logic           valid_q, valid_d;
    logic           eo_q,    eo_d;
    logic [W-1:0]   ptr_q,   ptr_d;

    logic [N-1:0]   req;
    logic [W-1:0]   search_start;
    logic           win_found;
    logic [W-1:0]   win_idx;
    int             j;

    assign req = ~iData;

    // Winner search: walk downward from the start index, wrapping past 0 to
    // N-1, and keep the first active request. Fixed mode always starts at
    // N-1, which reduces the walk to a plain highest-index-wins encoder.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        search_start = (RR_MODE != 0) ? ptr_q : W'(N - 1);
        win_found    = 1'b0;
        win_idx      = '0;
        j            = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(search_start) - k;
            if (j < 0) begin
                j = j + N;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = W'(j);
            end
        end
    end

    // Next-state and output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        // oEO tracks the inputs on every edge, whatever the controller state.
        eo_d    = iEI | ~(&iData);

        case (state_q)
            IDLE: begin
                // An acknowledge seen while idle is ignored.
                if (!iEI && win_found) begin
                    data_d  = win_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Request and enable changes are ignored while a grant is held.
                if (iAck) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    if (RR_MODE != 0) begin
                        ptr_d = (data_q == '0) ? W'(N - 1) : data_q - W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset. Reset abandons any grant in
    // flight and does not advance the pointer.
    always_ff @(posedge iClk) begin
        // NOTE: non-blocking assignments, so every register samples the
        // values from before this edge regardless of statement order.
        if (iRst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            eo_q    <= 1'b1;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            eo_q    <= eo_d;
            ptr_q   <= ptr_d;
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oEO    = eo_q;

endmodule

// File: tb/tb_pri_encoder_rr.sv
// Testbench for pri_encoder_rr. Three instances share control inputs:
// fixed priority with N=8, round-robin with N=8, and round-robin with N=5.
// A behavioural model follows the grant rules and is compared against every
// instance on each falling edge. Directed sequences with hand-computed
// expectations pin down known cases; a randomized phase follows them.
`timescale 1ns/1ps

module tb_pri_encoder_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       ei;
    logic       ack;
    logic [7:0] data8;
    logic [4:0] data5;

    logic [2:0] od  [3];
    logic       ov  [3];
    logic       oeo [3];

    always #5 clk = ~clk;

    pri_encoder_rr #(.N(8), .RR_MODE(0)) u_fix8 (
        .iClk(clk), .iRst(rst), .iEI(ei), .iData(data8), .iAck(ack),
        .oData(od[0]), .oValid(ov[0]), .oEO(oeo[0])
    );

    pri_encoder_rr #(.N(8), .RR_MODE(1)) u_rr8 (
        .iClk(clk), .iRst(rst), .iEI(ei), .iData(data8), .iAck(ack),
        .oData(od[1]), .oValid(ov[1]), .oEO(oeo[1])
    );

    pri_encoder_rr #(.N(5), .RR_MODE(1)) u_rr5 (
        .iClk(clk), .iRst(rst), .iEI(ei), .iData(data5), .iAck(ack),
        .oData(od[2]), .oValid(ov[2]), .oEO(oeo[2])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_n  [3] = '{8, 8, 5};
    bit  m_rr [3] = '{1'b0, 1'b1, 1'b1};
    int  m_data [3];
    int  m_p    [3];
    bit  m_valid[3];
    bit  m_eo   [3];
    bit  model_ok = 1'b0;

    // First active line found walking down from the start index with wraparound.
    function automatic int pick(input int n, input bit rr, input int p,
                                input logic [31:0] act);
        int s;
        int idx;
        s = rr ? p : n - 1;
        for (int k = 0; k < n; k++) begin
            idx = (s - k + n) % n;
            if (act[idx]) return idx;
        end
        return -1;
    endfunction

    logic [31:0] m_act;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            m_act = '0;
            if (i == 2) m_act[4:0] = ~data5;
            else        m_act[7:0] = ~data8;
            if (rst) begin
                m_valid[i] = 1'b0;
                m_data[i]  = 0;
                m_eo[i]    = 1'b1;
                m_p[i]     = m_n[i] - 1;
            end else begin
                if (m_valid[i]) begin
                    if (ack) begin
                        m_valid[i] = 1'b0;
                        m_p[i]     = (m_data[i] + m_n[i] - 1) % m_n[i];
                    end
                end else if (!ei && m_act != 0) begin
                    m_data[i]  = pick(m_n[i], m_rr[i], m_p[i], m_act);
                    m_valid[i] = 1'b1;
                end
                m_eo[i] = !(!ei && m_act == 0);
            end
        end
        if (rst) model_ok = 1'b1;
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("cmp_valid[%0d]", i), int'(ov[i]),  int'(m_valid[i]));
                check($sformatf("cmp_data[%0d]",  i), int'(od[i]),  m_data[i]);
                check($sformatf("cmp_eo[%0d]",    i), int'(oeo[i]), int'(m_eo[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [7:0] d8, input logic [4:0] d5,
                        input logic e, input logic a, input logic r);
        data8 = d8;
        data5 = d5;
        ei    = e;
        ack   = a;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    int exp_seq[5] = '{7, 5, 3, 1, 7};
    logic [7:0] act8;
    logic [4:0] act5;

    initial begin
        rst   = 1'b1;
        ei    = 1'b1;
        ack   = 1'b0;
        data8 = 8'hFF;
        data5 = 5'h1F;

        // Reset state
        step(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b1);
        step(8'hFF, 5'h1F, 1'b1, 1'b1, 1'b1);
        check("rst_valid", int'(ov[0]), 0);
        check("rst_data",  int'(od[0]), 0);
        check("rst_eo",    int'(oeo[0]), 1);

        // Fixed priority: lines 7 and 0 active, 7 wins, and wins again after ack
        step(8'b0111_1110, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("fix_grant_valid", int'(ov[0]), 1);
        check("fix_grant_data",  int'(od[0]), 7);
        step(8'b0111_1110, 5'h1F, 1'b0, 1'b1, 1'b0);
        check("fix_ack_valid", int'(ov[0]), 0);
        check("fix_ack_hold",  int'(od[0]), 7);
        step(8'b0111_1110, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("fix_regrant_data", int'(od[0]), 7);
        step(8'b0111_1110, 5'h1F, 1'b0, 1'b1, 1'b0);

        // No requests: oEO low when enabled, high when disabled, never a grant
        step(8'hFF, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("noreq_valid", int'(ov[0]), 0);
        check("noreq_eo",    int'(oeo[0]), 0);
        step(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b0);
        check("dis_valid", int'(ov[0]), 0);
        check("dis_eo",    int'(oeo[0]), 1);

        // Grant of 3 held through request withdrawal and disable
        step(8'hF7, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("hold_grant_data", int'(od[0]), 3);
        for (int c = 0; c < 5; c++) begin
            step(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b0);
            check("hold_valid", int'(ov[0]), 1);
            check("hold_data",  int'(od[0]), 3);
        end
        step(8'hFF, 5'h1F, 1'b1, 1'b1, 1'b0);
        check("hold_release_valid", int'(ov[0]), 0);
        check("hold_release_data",  int'(od[0]), 3);

        // Round-robin with 8 lines, lines 7,5,3,1 active
        step(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(8'h55, 5'h1F, 1'b0, 1'b0, 1'b0);
            check("rr8_seq_valid", int'(ov[1]), 1);
            check("rr8_seq_data",  int'(od[1]), exp_seq[k]);
            step(8'h55, 5'h1F, 1'b0, 1'b1, 1'b0);
            check("rr8_seq_ack", int'(ov[1]), 0);
        end

        // Round-robin with 5 lines: pointer wraps from 0 to 4
        step(8'hFF, 5'h1F, 1'b1, 1'b0, 1'b1);
        step(8'hFF, 5'b11110, 1'b0, 1'b0, 1'b0);
        check("rr5_bit0_data", int'(od[2]), 0);
        step(8'hFF, 5'b11110, 1'b0, 1'b1, 1'b0);
        step(8'hFF, 5'b01110, 1'b0, 1'b0, 1'b0);
        check("rr5_wrap_valid", int'(ov[2]), 1);
        check("rr5_wrap_data",  int'(od[2]), 4);
        step(8'hFF, 5'b01110, 1'b0, 1'b1, 1'b0);

        // Reset in mid-grant abandons it and restores the pointer to N-1
        step(8'hDF, 5'h1F, 1'b0, 1'b0, 1'b0);
        step(8'hDF, 5'h1F, 1'b0, 1'b1, 1'b0);
        step(8'hDF, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("rstg_pre_data", int'(od[1]), 5);
        step(8'hDF, 5'h1F, 1'b0, 1'b0, 1'b1);
        check("rstg_valid", int'(ov[1]), 0);
        check("rstg_data",  int'(od[1]), 0);
        check("rstg_eo",    int'(oeo[1]), 1);
        step(8'b0111_1011, 5'h1F, 1'b0, 1'b0, 1'b0);
        check("rstg_next_data", int'(od[1]), 7);
        step(8'b0111_1011, 5'h1F, 1'b0, 1'b1, 1'b0);

        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            act8 = 8'($urandom & $urandom);
            act5 = 5'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) act8 = '0;
            if ($urandom_range(0, 3) == 0) act5 = '0;
            step(~act8, ~act5,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
